// File: rtl/mult_pkg.sv
// Shared definitions for the wide multi-precision multiplier lanes: operand
// geometry, product slice bounds, product type and controller state encoding.
package mult_pkg;

    // Operand width and digit-serial geometry
    localparam int W     = 110;
    localparam int DIGIT = 10;
    localparam int NDIG  = W / DIGIT;

    // Digit counter width (counts 0..NDIG-1)
    localparam int CNT_W = 4;

    // Full product width and the slices returned by the two lanes
    localparam int PROD_W = 2 * W;
    localparam int PP_W   = W + DIGIT;
    localparam int MID_HI = 217;
    localparam int MID_LO = 110;
    localparam int MID_W  = MID_HI - MID_LO + 1;
    localparam int UP_HI  = 219;
    localparam int UP_LO  = 218;
    localparam int UP_W   = UP_HI - UP_LO + 1;

    // Full-width product / accumulator type
    typedef logic [PROD_W-1:0] prod_t;

    // Operation controller states
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Extract digit number idx (0 = most significant) of an operand
    function automatic logic [DIGIT-1:0] msb_digit(input logic [W-1:0] op,
                                                   input logic [CNT_W-1:0] idx);
        return DIGIT'(op >> (W - DIGIT - DIGIT * int'(idx)));
    endfunction

    // Horner step: shift the running sum one digit and add a partial product
    function automatic prod_t horner_step(input prod_t acc,
                                          input logic [PP_W-1:0] pp);
        return (acc << DIGIT) + {{(PROD_W - PP_W){1'b0}}, pp};
    endfunction

endpackage

// File: rtl/multiplier_middle_bits_if.sv
// Operand/result bundle for the middle-slice multiplier lane. The master
// supplies operands with a one-cycle start strobe; the slave returns the
// registered middle slice of the product.
interface multiplier_middle_bits_if;
    import mult_pkg::*;

    logic             en;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [MID_W-1:0] res;

    modport master (
        output en,
        output a,
        output b,
        input  res
    );

    modport slave (
        input  en,
        input  a,
        input  b,
        output res
    );

endinterface

// File: rtl/mult_digit_pp.sv
// Combinational 110 x 10 unsigned partial product. One digit of the
// multiplier times the full multiplicand, kept at full 120-bit width.
module mult_digit_pp
    import mult_pkg::*;
(
    input  logic [W-1:0]     a,
    input  logic [DIGIT-1:0] d,
    output logic [PP_W-1:0]  pp
);

    // Both factors zero-extended to the product width so nothing truncates
    logic [PP_W-1:0] a_ext;
    logic [PP_W-1:0] d_ext;

    assign a_ext = {{DIGIT{1'b0}}, a};
    assign d_ext = {{W{1'b0}}, d};
    assign pp    = a_ext * d_ext;

endmodule

// File: rtl/multiplier_middle_bits.sv
// Digit-serial 110 x 110 unsigned multiplier returning P[217:110].
// Operands are captured on the start strobe, then one 10-bit digit of b is
// folded in per cycle, most significant digit first (Horner form), so the
// accumulator holds the exact 220-bit product after 11 steps. The middle
// slice is registered one cycle later and held until the next result.
module multiplier_middle_bits
    import mult_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    multiplier_middle_bits_if.slave bus
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    prod_t              acc;
    logic               fin;
    logic [MID_W-1:0]   res_q;

    logic [DIGIT-1:0]   digit;
    logic [PP_W-1:0]    pp;
    prod_t              acc_nxt;

    // Current multiplier digit and the next accumulator value
    always_comb begin
        digit   = msb_digit(b_q, cnt);
        acc_nxt = horner_step(acc, pp);
    end

    mult_digit_pp u_pp (
        .a  (a_q),
        .d  (digit),
        .pp (pp)
    );

    // Operation controller, accumulator and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            fin   <= 1'b0;
            res_q <= '0;
        end else begin
            fin <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // Start strobes are ignored here; the operation runs out.
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(NDIG - 1)) begin
                        state <= IDLE;
                        fin   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // The result register moves only the cycle after the last digit.
            if (fin) begin
                res_q <= acc[MID_HI:MID_LO];
            end
        end
    end

    assign bus.res = res_q;

endmodule

// File: tb/tb_multiplier_middle_bits.sv
// Testbench for multiplier_middle_bits: directed corner operands, randomized
// operands against an arithmetic reference, strobes during an operation,
// mid-operation reset and reset/strobe collision.
module tb_multiplier_middle_bits;

    localparam int OW = 110;
    localparam int RW = 108;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    logic [RW-1:0] last_exp = '0;

    multiplier_middle_bits_if bus ();

    multiplier_middle_bits dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expectation
    task automatic chk(input string tag, input logic [RW-1:0] got,
                       input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: exact product with plain arithmetic, then the middle slice
    function automatic logic [RW-1:0] ref_mid(input logic [OW-1:0] x,
                                              input logic [OW-1:0] y);
        logic [2*OW-1:0] p;
        p = {{OW{1'b0}}, x} * {{OW{1'b0}}, y};
        return p[217:110];
    endfunction

    function automatic logic [OW-1:0] rand_op();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[OW-1:0];
    endfunction

    // One full operation; optionally pulses en again while busy
    task automatic run_op(input string tag, input logic [OW-1:0] x,
                          input logic [OW-1:0] y, input logic [RW-1:0] exp,
                          input bit poke);
        @(negedge clk);
        bus.en = 1'b1;
        bus.a  = x;
        bus.b  = y;
        @(negedge clk);
        bus.en = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            if (poke && i == 4) begin
                bus.en = 1'b1;
                bus.a  = rand_op();
                bus.b  = rand_op();
            end else begin
                bus.en = 1'b0;
            end
            @(negedge clk);
        end
        bus.en = 1'b0;
        chk({tag, "_hold"}, bus.res, last_exp);
        @(negedge clk);
        chk(tag, bus.res, exp);
        last_exp = exp;
    endtask

    logic [OW-1:0] ones;
    logic [OW-1:0] x;
    logic [OW-1:0] y;

    initial begin
        ones   = '1;
        bus.en = 1'b0;
        bus.a  = '0;
        bus.b  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_res", bus.res, '0);

        run_op("one_one", 110'd1, 110'd1, 108'd0, 1'b0);
        run_op("p120", 110'd1 << 60, 110'd1 << 60, 108'h400, 1'b0);
        run_op("all_ones", ones, ones, {{(RW-1){1'b1}}, 1'b0}, 1'b0);

        // Result must persist while idle
        repeat (20) @(negedge clk);
        chk("idle_hold", bus.res, last_exp);

        run_op("p218", 110'd1 << 109, 110'd1 << 109, 108'd0, 1'b0);

        // Randomized operands, every fourth one with a stray en while busy
        for (int n = 0; n < 1000; n++) begin
            x = rand_op();
            y = rand_op();
            run_op((n % 4 == 0) ? "rand_poke" : "rand", x, y, ref_mid(x, y),
                   (n % 4 == 0));
        end

        // Reset during cycle 5 of an operation aborts it
        @(negedge clk);
        bus.en = 1'b1;
        bus.a  = rand_op();
        bus.b  = rand_op();
        @(negedge clk);
        bus.en = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_res", bus.res, '0);
        last_exp = '0;
        repeat (14) @(negedge clk);
        chk("abort_quiet", bus.res, '0);
        run_op("after_abort", ones, ones, {{(RW-1){1'b1}}, 1'b0}, 1'b0);

        // Reset and en together: nothing is loaded
        @(negedge clk);
        rst    = 1'b1;
        bus.en = 1'b1;
        bus.a  = ones;
        bus.b  = ones;
        @(negedge clk);
        rst    = 1'b0;
        bus.en = 1'b0;
        chk("rst_en_res", bus.res, '0);
        repeat (14) @(negedge clk);
        chk("rst_en_noload", bus.res, '0);
        last_exp = '0;

        // A clean operation still works afterwards
        x = rand_op();
        y = rand_op();
        run_op("final", x, y, ref_mid(x, y), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
